// File: rtl/packet_filter_pkg.sv
// packet_filter_pkg: shared AXI-Stream beat width and arbiter state type.
package packet_filter_pkg;
   localparam int AXIS_BEAT_W = 16;
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request bit searching upward from last_idx+1, with wrap.
module rr_priority_picker #(
   parameter int N_PORTS = 4,
   parameter int IW      = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [IW-1:0]      last_idx,
   output logic               found,
   output logic [IW-1:0]      idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Walk offsets from farthest to nearest so the nearest hit is written last.
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         int j;
         j = (int'(last_idx) + 1 + k) % N_PORTS;
         if (req[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end
endmodule

// File: rtl/egress_frame_arbiter.sv
// egress_frame_arbiter: frame-atomic round-robin merge of N AXI-Stream ports onto one egress.
// Define FRAME_ARB_STATS_EN to build the per-port 16-bit completed-frame counters.
module egress_frame_arbiter
   import packet_filter_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = AXIS_BEAT_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_PORTS*DATA_W-1:0]   ingress_tdata,
   input  logic [N_PORTS-1:0]          ingress_tvalid,
   input  logic [N_PORTS-1:0]          ingress_tlast,
   output logic [N_PORTS-1:0]          ingress_tready,
   output logic [DATA_W-1:0]           egress_tdata,
   output logic                        egress_tvalid,
   output logic                        egress_tlast,
   input  logic                        egress_tready,
   input  logic [N_PORTS-1:0]          port_enable,
   output logic                        grant_valid,
   output logic [$clog2(N_PORTS)-1:0]  grant_idx,
   output logic [N_PORTS*16-1:0]       frame_count
);
   localparam int IW = $clog2(N_PORTS);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] grant_idx_q, grant_idx_d, last_idx_q, last_idx_d, pick_idx;
   logic [N_PORTS-1:0] req;
   logic          pick_found;

   assign req = ingress_tvalid & port_enable;

   rr_priority_picker #(.N_PORTS(N_PORTS), .IW(IW)) u_picker (
      .req      (req),
      .last_idx (last_idx_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         grant_idx_q <= '0;
         last_idx_q  <= IW'(N_PORTS - 1);
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         last_idx_q  <= last_idx_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_idx_d    = grant_idx_q;
      last_idx_d     = last_idx_q;
      egress_tdata   = '0;
      egress_tvalid  = 1'b0;
      egress_tlast   = 1'b0;
      ingress_tready = '0;
      if (state_q == ARB_IDLE) begin
         if (pick_found) begin
            state_d     = ARB_LOCKED;
            grant_idx_d = pick_idx;
         end
      end else begin
         egress_tdata                = ingress_tdata[int'(grant_idx_q)*DATA_W +: DATA_W];
         egress_tvalid               = ingress_tvalid[grant_idx_q];
         egress_tlast                = ingress_tlast[grant_idx_q];
         ingress_tready[grant_idx_q] = egress_tready;
         if (ingress_tvalid[grant_idx_q] && egress_tready && ingress_tlast[grant_idx_q]) begin
            state_d    = ARB_IDLE;
            last_idx_d = grant_idx_q;
         end
      end
   end

   assign grant_valid = (state_q == ARB_LOCKED);
   assign grant_idx   = grant_idx_q;

`ifdef FRAME_ARB_STATS_EN
   logic frame_done;
   assign frame_done = egress_tvalid & egress_tready & egress_tlast;
   for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
      logic [15:0] cnt_q;
      always_ff @(posedge clk) begin
         if (reset) cnt_q <= '0;
         else if (frame_done && grant_idx_q == IW'(i)) cnt_q <= cnt_q + 16'd1;
      end
      assign frame_count[i*16 +: 16] = cnt_q;
   end
`else
   assign frame_count = '0;
`endif
endmodule

// File: doc/egress_frame_arbiter.md
# egress_frame_arbiter

Frame-atomic round-robin arbiter that merges N 16-bit AXI-Stream frame sources, such as several frame generators or filter egress lanes, onto one egress stream. A grant is held from the first beat of a frame through its tlast handshake, so frames are never interleaved. It sits between the traffic sources and the single downstream consumer (MAC/filter ingress) and allows per-port enable control.

## Interface
Parameters:
- N_PORTS, 4: number of ingress ports; legal range 2..8.
- DATA_W, 16: stream data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ingress_tdata  in  N_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- ingress_tvalid  in  N_PORTS  per-port valid.
- ingress_tlast  in  N_PORTS  per-port last beat of frame.
- ingress_tready  out  N_PORTS  per-port ready.
- egress_tdata  out  DATA_W  merged data.
- egress_tvalid  out  1  merged valid.
- egress_tlast  out  1  merged last.
- egress_tready  in  1  downstream ready.
- port_enable  in  N_PORTS  1 = port may win arbitration.
- grant_valid  out  1  a port currently owns egress.
- grant_idx  out  $clog2(N_PORTS)  owning port.
- frame_count  out  N_PORTS*16  per-port completed-frame counters (see Configuration).

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - All ingress_tready = 0; egress_tvalid = 0.
  - Request vector req = ingress_tvalid & port_enable.
  - If req != 0, pick the first set bit searching from (last_idx+1) mod N_PORTS upward with wrap. Register it into grant_idx, set grant_valid = 1, and go to LOCKED.
- LOCKED:
  - Pure combinational pass-through of the granted port: egress_t{data,valid,last} = ingress_*[grant_idx]; ingress_tready[grant_idx] = egress_tready; all other tready = 0.
  - On egress_tvalid & egress_tready & egress_tlast: set last_idx ← grant_idx, clear grant_valid, and return to IDLE.
- port_enable is sampled only in IDLE. Deasserting it mid-frame does not break the grant.
- A granted source dropping tvalid mid-frame stalls egress; the grant is held indefinitely.
- Non-granted ports see tready = 0 and must hold their data.
- Single-beat frames (tlast on first beat) are legal.

## Timing
- Reset values: state = IDLE, grant_valid = 0, grant_idx = 0, last_idx = N_PORTS-1 (port 0 has first priority), all tready = 0, egress_tvalid = 0, egress_tlast = 0, egress_tdata = 0, frame_count = 0.
- Arbitration latency: tvalid seen in IDLE at cycle t; the first beat is offered on egress at t+1.
- Frame-to-frame: one IDLE bubble cycle after each tlast handshake. Back-to-back frames therefore cost 1 dead cycle.
- Egress data path is combinational, so the stream handshake adds zero latency inside LOCKED.
- Simultaneous requests: round-robin only, with no fixed priority beyond the reset pointer.
- Reset mid-frame: immediate return to IDLE and the partial frame is abandoned. Sources are reset by the same signal.
- No state change while egress_tready = 0 in LOCKED.

## Configuration
- FRAME_ARB_STATS_EN:
  - Defined: frame_count[i] is a 16-bit counter that increments by 1 on each tlast handshake from port i, wraps at 0xFFFF → 0, and clears on reset.
  - Undefined: frame_count is tied to 0 and no counter flops are generated.
  - Arbitration behaviour is identical either way.

## Structure
- Shared packet_filter package/header: the AXI-Stream beat width constant (16) and a typedef for the arbiter state enum (ARB_IDLE, ARB_LOCKED).
- One sub-module, rr_priority_picker: combinational, with inputs req[N_PORTS] and last_idx and outputs found and idx. It rotates req, takes the lowest set bit, and un-rotates.
- Top level holds the FSM, the grant registers, the mux and the optional counters.

## Test plan
- Reset, then port 0 sends a 3-beat frame (0xAAAA, 0x1234, 0x5678 with tlast) and egress_tready is held 1: egress shows those beats at cycles t+1..t+3, grant_idx = 0, and grant_valid falls after the tlast handshake.
- All 4 ports continuously valid with 2-beat frames: grant order is 0, 1, 2, 3, 0, … with exactly one idle cycle between frames and no interleaving.
- port_enable = 4'b1011 with all ports valid: port 2 is never granted. Clearing enable[0] mid-frame of port 0 still completes that frame.
- egress_tready toggled 1,0,0,1 during port 1's frame: ingress_tready[1] mirrors it, other tready stay 0, and data is held stable during the stall.
- Reset asserted on the 2nd beat of a port 3 frame: next cycle state is IDLE, outputs are at their reset values, and the next simultaneous request from ports 0 and 3 grants port 0.
- With FRAME_ARB_STATS_EN defined: 5 frames from port 2 give frame_count[2] = 5 and the others 0. Preloading to 0xFFFF and sending one more frame wraps to 0.
